// File: rtl/bcd_to_binary_pkg.sv
// Shared constants and types for the BCD conversion blocks.
// The adjust threshold/value pair mirrors the binary-to-BCD block's 5/+3 rule.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_VAL    = 4'd3;

    function automatic logic digit_invalid(input logic [3:0] d);
        return (d > DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// Request/result bundle between a BCD producer and the bcd_to_binary converter.
interface bcd_to_binary_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) ();

    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (
        output start, bcd_in,
        input  busy, done, bin_out, err
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, bin_out, err
    );

endinterface

// File: rtl/bcd_to_binary_digit_adjust.sv
// Single-digit correction for reverse double-dabble: digits >= 8 after a
// right shift drop by 3 (4-bit modulo, never borrows from a neighbour).
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    // Conditional subtract of the adjust value
    always_comb begin
        q = d;
        if (d >= ADJ_THRESH) begin
            q = d - ADJ_VAL;
        end else begin
            q = d;
        end
    end

endmodule

// File: rtl/bcd_to_binary.sv
// Multi-cycle BCD-to-binary converter using reverse double-dabble, one
// shift per clock; invalid digits short-circuit straight to a flagged result.
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    bcd_to_binary_if.slave   bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t            state_r;
    state_t            state_next_s;
    logic [BCD_W-1:0]  bcd_sr_r;
    logic [BIN_W-1:0]  bin_sr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r;
    logic              done_r;
    logic [BIN_W-1:0]  bin_out_r;
    logic              err_r;

    logic [BCD_W-1:0]  bcd_shift_s;
    logic [BCD_W-1:0]  bcd_adj_s;
    logic [BIN_W-1:0]  bin_shift_s;
    logic              bad_digit_s;
    logic              load_s;
    logic              shift_s;
    logic              finish_ok_s;
    logic              finish_err_s;

    // The BCD register's LSB moves into the binary register's MSB
    assign bcd_shift_s = {1'b0, bcd_sr_r[BCD_W-1:1]};
    assign bin_shift_s = {bcd_sr_r[0], bin_sr_r[BIN_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .d (bcd_shift_s[4*g +: 4]),
            .q (bcd_adj_s[4*g +: 4])
        );
    end

    // Flag any non-decimal digit in the incoming operand
    always_comb begin
        bad_digit_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad_digit_s = bad_digit_s | digit_invalid(bus.bcd_in[4*i +: 4]);
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        finish_ok_s  = 1'b0;
        finish_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    load_s = 1'b1;
                    if (bad_digit_s) begin
                        state_next_s = DONE;
                        finish_err_s = 1'b1;
                    end else begin
                        state_next_s = CONV;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            CONV: begin
                shift_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_next_s = DONE;
                    finish_ok_s  = 1'b1;
                end else begin
                    state_next_s = CONV;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, shift registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            bcd_sr_r  <= '0;
            bin_sr_r  <= '0;
            cnt_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            bin_out_r <= '0;
            err_r     <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == CONV);
            done_r  <= (state_next_s == DONE);

            if (load_s) begin
                bcd_sr_r <= bus.bcd_in;
                bin_sr_r <= '0;
                cnt_r    <= '0;
            end else if (shift_s) begin
                bcd_sr_r <= bcd_adj_s;
                bin_sr_r <= bin_shift_s;
                cnt_r    <= cnt_r + CNT_W'(1);
            end else begin
                bcd_sr_r <= bcd_sr_r;
                bin_sr_r <= bin_sr_r;
                cnt_r    <= cnt_r;
            end

            // Result lands on the edge entering DONE so it is valid with the pulse
            if (finish_ok_s) begin
                bin_out_r <= bin_shift_s;
                err_r     <= 1'b0;
            end else if (finish_err_s) begin
                bin_out_r <= '0;
                err_r     <= 1'b1;
            end else begin
                bin_out_r <= bin_out_r;
                err_r     <= err_r;
            end
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.bin_out = bin_out_r;
    assign bus.err     = err_r;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: directed scenarios plus a full 000..999 sweep.
module tb_bcd_to_binary;

    logic clk;
    logic rst;

    bcd_to_binary_if #(.DIGITS(3), .BIN_W(10)) bus ();

    bcd_to_binary #(.DIGITS(3), .BIN_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [11:0] bcd;
        logic [9:0]  bin;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic prev_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_model(input logic [11:0] bcd);
        exp_t e;
        int   d0, d1, d2;
        d0 = int'(bcd[3:0]);
        d1 = int'(bcd[7:4]);
        d2 = int'(bcd[11:8]);
        e.bcd = bcd;
        if (d0 > 9 || d1 > 9 || d2 > 9) begin
            e.err = 1'b1;
            e.bin = 10'd0;
        end else begin
            e.err = 1'b0;
            e.bin = 10'(d2 * 100 + d1 * 10 + d0);
        end
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest accepted request
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            exp_t e;
            check_val("done_width", int'(prev_done), 0);
            if (sb_q.size() == 0) begin
                check_val("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check_val($sformatf("bin_%03h", e.bcd), int'(bus.bin_out), int'(e.bin));
                check_val($sformatf("err_%03h", e.bcd), int'(bus.err), int'(e.err));
                if (!e.err) begin
                    check_val($sformatf("residue_%03h", e.bcd), int'(dut.bcd_sr_r), 0);
                end
            end
        end
        prev_done = bus.done;
    end

    task automatic run(input logic [11:0] bcd, input int exp_lat, input int exp_busy);
        int   lat;
        int   busy_n;
        logic seen;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        sb_q.push_back(ref_model(bcd));
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.bcd_in = ~bcd;
        lat    = 0;
        busy_n = 0;
        seen   = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_n++;
            if (bus.done) seen = 1'b1;
        end
        check_val($sformatf("latency_%03h", bcd), lat, exp_lat);
        check_val($sformatf("busy_%03h", bcd), busy_n, exp_busy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int done_n;
        int first_done;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bcd_in = 12'h000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", int'(bus.busy), 0);
        check_val("rst_done", int'(bus.done), 0);
        check_val("rst_bin", int'(bus.bin_out), 0);
        check_val("rst_err", int'(bus.err), 0);
        rst = 1'b0;

        run(12'h000, 11, 10);
        run(12'h999, 11, 10);
        run(12'h255, 11, 10);
        run(12'h100, 11, 10);
        run(12'h1A5, 1, 0);
        run(12'h042, 11, 10);

        // Second start mid-conversion must be ignored
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h123;
        sb_q.push_back(ref_model(12'h123));
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        lat        = 0;
        done_n     = 0;
        first_done = -1;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 3) begin
                bus.start  = 1'b1;
                bus.bcd_in = 12'h777;
            end else begin
                bus.start  = 1'b0;
            end
            if (bus.done) begin
                done_n++;
                if (first_done < 0) first_done = lat;
            end
        end
        check_val("ignore_done_count", done_n, 1);
        check_val("ignore_latency", first_done, 11);

        // Reset mid-conversion aborts without a done pulse
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h321;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_busy", int'(bus.busy), 0);
        check_val("abort_done", int'(bus.done), 0);
        check_val("abort_bin", int'(bus.bin_out), 0);
        check_val("abort_err", int'(bus.err), 0);
        rst    = 1'b0;
        done_n = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done) done_n++;
        end
        check_val("abort_no_done", done_n, 0);
        run(12'h512, 11, 10);

        // Exhaustive sweep of valid operands
        for (int i = 0; i < 1000; i++) begin
            logic [11:0] b;
            b = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
            run(b, 11, 10);
        end

        // Random operands with at least one non-decimal digit
        for (int i = 0; i < 20; i++) begin
            logic [11:0] b;
            int          pos;
            b   = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            pos = int'($urandom_range(0, 2));
            b[4*pos +: 4] = 4'($urandom_range(10, 15));
            run(b, 1, 0);
        end

        repeat (3) @(negedge clk);
        check_val("sb_leftover", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
